alu_serial_sequencer: RTL and testbench
=======================================

ALU_SERIAL_SEQUENCER -- requirements
Module: alu_serial_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (WIDTH >= 2).
REQ-002 Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request to begin an operation; sampled only when Ready=1.
REQ-005 Op  input  2  operation: 00 ADD, 01 SUB, 10 ADC, 11 SBB.
REQ-006 A  input  WIDTH  first operand; latched on Start acceptance.
REQ-007 B  input  WIDTH  second operand; latched on Start acceptance.
REQ-008 CarryIn  input  1  carry for ADC/SBB; latched on Start acceptance.
REQ-009 Ack  input  1  consumer acknowledge of Valid result.
REQ-010 Ready  output  1  high in IDLE only; Start accepted when Start=1 and Ready=1.
REQ-011 Busy  output  1  high in SHIFT and FLAGS states.
REQ-012 Valid  output  1  high in DONE; Result and flags are valid.
REQ-013 Result  output  WIDTH  operation result.
REQ-014 isOverflow, isCarry, isZero, isSign  output  1 each  result flags.

Function
REQ-015 States IDLE, SHIFT, FLAGS, DONE; exactly one active each cycle.
REQ-016 IDLE -> SHIFT when Start=1; latch A, B, CarryIn, Op; clear bit counter to 0.
REQ-017 Processed B (Bp) = B for ADD/ADC, ~B for SUB/SBB; fixed for the whole operation.
REQ-018 Initial carry = 0 for ADD, 1 for SUB, CarryIn for ADC and SBB.
REQ-019 SHIFT: one bit per cycle, LSB first, via a single 1-bit full adder; carry register updated each cycle; result bit i written in cycle i of SHIFT.
REQ-020 SHIFT lasts exactly WIDTH cycles; counter reaching WIDTH-1 moves to FLAGS.
REQ-021 FLAGS: one cycle; registers isCarry = final carry out, isSign = Result[WIDTH-1], isZero = (Result == 0), isOverflow = (A[WIDTH-1] xor Result[WIDTH-1]) and (Bp[WIDTH-1] xor Result[WIDTH-1]); then -> DONE.
REQ-022 Latency: Start accepted at edge T -> Valid=1 from cycle T+WIDTH+2 (T+10 for WIDTH=8).
REQ-023 DONE: Valid held high, Result and flags stable, until Ack=1 sampled; then -> IDLE next cycle.
REQ-024 Start while Ready=0 (SHIFT, FLAGS, DONE) ignored; no queuing.
REQ-025 Start and Ack in same DONE cycle: Ack honoured, Start ignored; Start must be re-presented in IDLE.
REQ-026 Ack outside DONE ignored.
REQ-027 Operand inputs changing after acceptance have no effect on the running operation.
REQ-028 Result and flags retain last values in IDLE; overwritten only by the next operation (Result bits during SHIFT, flags at FLAGS).
REQ-029 Carry semantics: SUB/SBB isCarry=1 means no borrow.

Reset
REQ-030 Reset=1 at an edge: state IDLE, Ready=1, Busy=0, Valid=0, Result=0, all flags=0, counter=0, carry=0.
REQ-031 Reset takes priority over Start and Ack in the same cycle.
REQ-032 Reset mid-operation aborts it; no Valid pulse is produced for the aborted operation.

Verification (WIDTH=8)
REQ-033 ADD A=0x7F B=0x01 -> Valid at T+10, Result=0x80, V=1 C=0 Z=0 S=1.
REQ-034 SUB A=0x80 B=0x01 -> Result=0x7F, V=1 C=1 Z=0 S=0; SUB A=0x05 B=0x05 -> Result=0x00, Z=1 C=1 V=0.
REQ-035 ADC A=0xFF B=0x00 CarryIn=1 -> Result=0x00, C=1 Z=1 V=0 S=0; SBB A=0x10 B=0x01 CarryIn=0 -> Result=0x0E, C=1.
REQ-036 Start held high throughout an operation, Ack delayed 3 cycles -> Valid high 3 cycles, Result/flags stable, no second operation until Ready=1 then Start re-sampled.
REQ-037 Reset asserted at T+4 of an ADD -> next cycle Ready=1, Busy=0, Valid=0, Result=0, flags=0; a following Start completes normally with correct result.
REQ-038 Start and Ack together in DONE -> IDLE next cycle, Ready=1, no new operation started.

Source files
------------

// File: rtl/alu_serial_sequencer.sv
// rtl/alu_serial_sequencer.sv - bit-serial add/subtract sequencer with carry-in and result flags
// One full adder is reused across WIDTH SHIFT cycles, LSB first; flags are registered in FLAGS.

module alu_serial_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CarryIn,
   input  logic             Ack,
   output logic             Ready,
   output logic             Busy,
   output logic             Valid,
   output logic [WIDTH-1:0] Result,
   output logic             isOverflow,
   output logic             isCarry,
   output logic             isZero,
   output logic             isSign
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FLAGS = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic [CW-1:0]    count;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] bp_q;
   logic             carry;
   logic             sum_bit;
   logic             carry_out;
   logic             a_bit;
   logic             bp_bit;

   always_comb begin
      a_bit     = a_q[count];
      bp_bit    = bp_q[count];
      sum_bit   = a_bit ^ bp_bit ^ carry;
      carry_out = (a_bit & bp_bit) | (a_bit & carry) | (bp_bit & carry);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      Ready      = 1'b0;
      Busy       = 1'b0;
      Valid      = 1'b0;
      case (state)
         IDLE: begin
            Ready = 1'b1;
            if (Start) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            Busy = 1'b1;
            if (count == LAST_BIT) begin
               state_next = FLAGS;
            end
         end
         FLAGS: begin
            Busy       = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            Valid = 1'b1;
            if (Ack) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Op[0] selects subtraction (invert B), Op[1] selects the external carry as the seed.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         count      <= '0;
         carry      <= 1'b0;
         a_q        <= '0;
         bp_q       <= '0;
         Result     <= '0;
         isOverflow <= 1'b0;
         isCarry    <= 1'b0;
         isZero     <= 1'b0;
         isSign     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  a_q   <= A;
                  bp_q  <= Op[0] ? ~B : B;
                  carry <= Op[1] ? CarryIn : Op[0];
                  count <= '0;
               end
            end
            SHIFT: begin
               Result[count] <= sum_bit;
               carry         <= carry_out;
               count         <= count + 1'b1;
            end
            FLAGS: begin
               isCarry    <= carry;
               isSign     <= Result[WIDTH-1];
               isZero     <= ~|Result;
               isOverflow <= (a_q[WIDTH-1] ^ Result[WIDTH-1]) &
                             (bp_q[WIDTH-1] ^ Result[WIDTH-1]);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// tb/tb_alu_serial_sequencer.sv - directed self-checking bench for alu_serial_sequencer
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_alu_serial_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [1:0] op;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       ack;
   logic       ready;
   logic       busy;
   logic       valid;
   logic [7:0] result;
   logic       f_v;
   logic       f_c;
   logic       f_z;
   logic       f_s;

   int pass_cnt = 0;
   int total_cnt = 0;

   alu_serial_sequencer #(.WIDTH(8)) dut (
      .Clock(clk), .Reset(rst), .Start(start), .Op(op), .A(a), .B(b),
      .CarryIn(cin), .Ack(ack), .Ready(ready), .Busy(busy), .Valid(valid),
      .Result(result), .isOverflow(f_v), .isCarry(f_c), .isZero(f_z), .isSign(f_s)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one operation, scrambles operands after acceptance, waits (bounded) for Valid.
   task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic ci, output int lat);
      op = o; a = x; b = y; cin = ci; start = 1'b1;
      tick();
      start = 1'b0;
      op = ~o; a = ~x; b = x ^ y ^ 8'h5A; cin = ~ci;
      lat = 0;
      while (valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; ack = 1'b1; op = 2'b00; a = 8'hAA; b = 8'h55; cin = 1'b1;
      tick();
      tick();
      total_cnt++;
      if ({ready, busy, valid} !== 3'b100) $display("FAIL reset_status: got %b exp 100", {ready, busy, valid});
      else pass_cnt++;
      total_cnt++;
      if ({result, f_v, f_c, f_z, f_s} !== 12'h000) $display("FAIL reset_result: got %h/%b exp 00/0000", result, {f_v, f_c, f_z, f_s});
      else pass_cnt++;
      rst = 1'b0; start = 1'b0; ack = 1'b0;
      tick();
      total_cnt++;
      if ({ready, busy} !== 2'b10) $display("FAIL reset_idle: got %b exp 10", {ready, busy});
      else pass_cnt++;
   endtask

   task automatic test_arith();
      logic [1:0] t_op[10]  = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
      logic [7:0] t_a[10]   = '{8'h7F, 8'h80, 8'h05, 8'hFF, 8'h10, 8'hFF, 8'h00, 8'h7F, 8'h10, 8'h01};
      logic [7:0] t_b[10]   = '{8'h01, 8'h01, 8'h05, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01};
      logic       t_ci[10]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [7:0] t_r[10]   = '{8'h80, 8'h7F, 8'h00, 8'h00, 8'h0E, 8'h00, 8'hFF, 8'h80, 8'h0F, 8'h02};
      logic [3:0] t_f[10]   = '{4'b1001, 4'b1100, 4'b0110, 4'b0110, 4'b0100,
                                4'b0110, 4'b0001, 4'b1001, 4'b0100, 4'b0000};
      int lat;
      for (int i = 0; i < 10; i++) begin
         run_op(t_op[i], t_a[i], t_b[i], t_ci[i], lat);
         total_cnt++;
         if (lat !== 9) $display("FAIL arith%0d_latency: got %0d exp 9", i, lat);
         else pass_cnt++;
         total_cnt++;
         if (result !== t_r[i]) $display("FAIL arith%0d_result: got %h exp %h", i, result, t_r[i]);
         else pass_cnt++;
         total_cnt++;
         if ({f_v, f_c, f_z, f_s} !== t_f[i]) $display("FAIL arith%0d_flags_vczs: got %b exp %b", i, {f_v, f_c, f_z, f_s}, t_f[i]);
         else pass_cnt++;
         ack = 1'b1;
         tick();
         ack = 1'b0;
         total_cnt++;
         if ({ready, valid, result} !== {2'b10, t_r[i]}) $display("FAIL arith%0d_after_ack: got %b/%h exp 10/%h", i, {ready, valid}, result, t_r[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_start_held();
      int lat;
      op = 2'b00; a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
      tick();
      lat = 0;
      while (valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      total_cnt++;
      if (lat !== 9) $display("FAIL held_latency: got %0d exp 9", lat);
      else pass_cnt++;
      for (int k = 0; k < 2; k++) begin
         tick();
         total_cnt++;
         if ({valid, busy, result, f_v, f_c, f_z, f_s} !== {2'b10, 8'h46, 4'b0000})
            $display("FAIL held_done_stable%0d: got %b/%h/%b exp 10/46/0000", k, {valid, busy}, result, {f_v, f_c, f_z, f_s});
         else pass_cnt++;
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      total_cnt++;
      if ({ready, valid, busy} !== 3'b100) $display("FAIL held_back_idle: got %b exp 100", {ready, valid, busy});
      else pass_cnt++;
      a = 8'h01; b = 8'h02;
      tick();
      start = 1'b0;
      total_cnt++;
      if ({ready, busy} !== 2'b01) $display("FAIL held_resample: got %b exp 01", {ready, busy});
      else pass_cnt++;
      lat = 0;
      while (valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      total_cnt++;
      if (lat !== 9 || result !== 8'h03) $display("FAIL held_second_op: got lat %0d result %h exp 9/03", lat, result);
      else pass_cnt++;
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat;
      int vcount;
      op = 2'b00; a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total_cnt++;
      if ({ready, busy, valid} !== 3'b100) $display("FAIL midreset_status: got %b exp 100", {ready, busy, valid});
      else pass_cnt++;
      total_cnt++;
      if ({result, f_v, f_c, f_z, f_s} !== 12'h000) $display("FAIL midreset_cleared: got %h/%b exp 00/0000", result, {f_v, f_c, f_z, f_s});
      else pass_cnt++;
      vcount = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (valid === 1'b1 || ready !== 1'b1) vcount++;
      end
      total_cnt++;
      if (vcount !== 0) $display("FAIL midreset_no_valid: got %0d bad cycles exp 0", vcount);
      else pass_cnt++;
      run_op(2'b00, 8'h0F, 8'h01, 1'b0, lat);
      total_cnt++;
      if (lat !== 9 || result !== 8'h10 || {f_v, f_c, f_z, f_s} !== 4'b0000)
         $display("FAIL midreset_recover: got lat %0d result %h flags %b exp 9/10/0000", lat, result, {f_v, f_c, f_z, f_s});
      else pass_cnt++;
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic test_start_ack_together();
      int lat;
      run_op(2'b01, 8'h00, 8'h01, 1'b0, lat);
      total_cnt++;
      if (lat !== 9 || result !== 8'hFF || {f_v, f_c, f_z, f_s} !== 4'b0001)
         $display("FAIL together_op: got lat %0d result %h flags %b exp 9/FF/0001", lat, result, {f_v, f_c, f_z, f_s});
      else pass_cnt++;
      start = 1'b1; ack = 1'b1;
      tick();
      start = 1'b0; ack = 1'b0;
      total_cnt++;
      if ({ready, busy, valid} !== 3'b100) $display("FAIL together_idle: got %b exp 100", {ready, busy, valid});
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({ready, busy, result} !== {2'b10, 8'hFF}) $display("FAIL together_no_new_op: got %b/%h exp 10/FF", {ready, busy}, result);
      else pass_cnt++;
   endtask

   task automatic test_ack_outside();
      int lat;
      ack = 1'b1;
      tick();
      total_cnt++;
      if ({ready, busy, valid} !== 3'b100) $display("FAIL ackidle_status: got %b exp 100", {ready, busy, valid});
      else pass_cnt++;
      op = 2'b00; a = 8'h20; b = 8'h22; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      while (valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
         if (lat == 4) ack = 1'b0;
      end
      total_cnt++;
      if (lat !== 9 || result !== 8'h42) $display("FAIL ackbusy_op: got lat %0d result %h exp 9/42", lat, result);
      else pass_cnt++;
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; ack = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00; cin = 1'b0;
      test_reset();
      test_arith();
      test_start_held();
      test_reset_mid();
      test_start_ack_together();
      test_ack_outside();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
